// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART frame parser: FSM state encodings, default
// sync marker and the sample width.
package uart_frame_pkg;

  localparam int SAMPLE_W = 16;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [2:0] s_IDLE  = 3'd0;
  localparam logic [2:0] s_LEN   = 3'd1;
  localparam logic [2:0] s_LSB   = 3'd2;
  localparam logic [2:0] s_MSB   = 3'd3;
  localparam logic [2:0] s_CHK   = 3'd4;
  localparam logic [2:0] s_DRAIN = 3'd5;

endpackage

// File: rtl/frame_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port
// with read enable so the read register can hold a prefetched sample.
module frame_sample_ram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Parses sync/length/16-bit LE samples(/checksum) frames from the UART byte
// stream and drains validated frames over valid/ready. Option: FRAME_CHECKSUM_EN.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int         MAX_SAMPLES = 64,
  parameter int         ADDR_W      = 6
) (
  input  logic                i_Clock,
  input  logic                i_Reset_n,
  input  logic                i_Rx_DV,
  input  logic [7:0]          i_Rx_Byte,
  output logic                o_Sample_DV,
  output logic [SAMPLE_W-1:0] o_Sample,
  output logic                o_Sample_Last,
  input  logic                i_Sample_Ready,
  output logic                o_Err_Len,
  output logic                o_Err_Chk,
  output logic                o_Overrun,
  output logic                o_Busy
);

  localparam int         CNT_W   = ADDR_W + 1;
  localparam logic [7:0] MAX_LEN = 8'(MAX_SAMPLES);

  logic [2:0]          state_q, state_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          low_q, low_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    rd_idx_q, rd_idx_d;
  logic                rd_vld_q, rd_vld_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                dv_q, dv_d;
  logic                last_q, last_d;
  logic                err_len_q, err_len_d;
  logic                overrun_q, overrun_d;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
  logic                err_chk_q, err_chk_d;
`endif

  logic                wr_en, rd_en, load_out, accept;
  logic [SAMPLE_W-1:0] ram_rd_data;
  logic [CNT_W-1:0]    idx_inc;
  logic                idx_done, rd_more;

  assign idx_inc  = idx_q + CNT_W'(1);
  assign idx_done = (9'(idx_inc) == 9'(len_q));
  assign rd_more  = (9'(rd_idx_q) != 9'(len_q));
  assign accept   = dv_q & i_Sample_Ready;
  // The RAM read register acts as a one-entry prefetch slot behind the output register.
  assign load_out = (state_q == s_DRAIN) && rd_vld_q && (!dv_q || i_Sample_Ready);
  assign rd_en    = (state_q == s_DRAIN) && rd_more && (!rd_vld_q || load_out);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    low_d     = low_q;
    idx_d     = idx_q;
    rd_idx_d  = rd_idx_q;
    rd_vld_d  = rd_vld_q;
    sample_d  = sample_q;
    dv_d      = dv_q;
    last_d    = last_q;
    err_len_d = 1'b0;
    overrun_d = i_Rx_DV && (state_q == s_DRAIN);
    wr_en     = 1'b0;
`ifdef FRAME_CHECKSUM_EN
    sum_d     = sum_q;
    err_chk_d = 1'b0;
`endif
    case (state_q)
      s_IDLE: if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) state_d = s_LEN;
      s_LEN: if (i_Rx_DV) begin
        if (i_Rx_Byte == 8'd0 || i_Rx_Byte > MAX_LEN) begin
          err_len_d = 1'b1;
          state_d   = s_IDLE;
        end else begin
          len_d   = i_Rx_Byte;
          idx_d   = '0;
          state_d = s_LSB;
`ifdef FRAME_CHECKSUM_EN
          sum_d   = i_Rx_Byte;
`endif
        end
      end
      s_LSB: if (i_Rx_DV) begin
        low_d   = i_Rx_Byte;
        state_d = s_MSB;
`ifdef FRAME_CHECKSUM_EN
        sum_d   = sum_q + i_Rx_Byte;
`endif
      end
      s_MSB: if (i_Rx_DV) begin
        wr_en = 1'b1;
        idx_d = idx_inc;
`ifdef FRAME_CHECKSUM_EN
        sum_d = sum_q + i_Rx_Byte;
        state_d = idx_done ? s_CHK : s_LSB;
`else
        if (idx_done) begin
          state_d  = s_DRAIN;
          rd_idx_d = '0;
          rd_vld_d = 1'b0;
        end else begin
          state_d = s_LSB;
        end
`endif
      end
`ifdef FRAME_CHECKSUM_EN
      s_CHK: if (i_Rx_DV) begin
        if (i_Rx_Byte == sum_q) begin
          state_d  = s_DRAIN;
          rd_idx_d = '0;
          rd_vld_d = 1'b0;
        end else begin
          err_chk_d = 1'b1;
          state_d   = s_IDLE;
        end
      end
`endif
      s_DRAIN: begin
        if (rd_en) begin
          rd_idx_d = rd_idx_q + CNT_W'(1);
          rd_vld_d = 1'b1;
        end else if (load_out) begin
          rd_vld_d = 1'b0;
        end
        // The read slot always holds sample rd_idx_q-1, so it is last when rd_idx_q == N.
        if (load_out) begin
          sample_d = ram_rd_data;
          dv_d     = 1'b1;
          last_d   = (9'(rd_idx_q) == 9'(len_q));
        end else if (accept) begin
          dv_d   = 1'b0;
          last_d = 1'b0;
        end
        if (accept && last_q) state_d = s_IDLE;
      end
      default: state_d = s_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= s_IDLE;
      len_q     <= '0;
      low_q     <= '0;
      idx_q     <= '0;
      rd_idx_q  <= '0;
      rd_vld_q  <= 1'b0;
      sample_q  <= '0;
      dv_q      <= 1'b0;
      last_q    <= 1'b0;
      err_len_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      sum_q     <= '0;
      err_chk_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      low_q     <= low_d;
      idx_q     <= idx_d;
      rd_idx_q  <= rd_idx_d;
      rd_vld_q  <= rd_vld_d;
      sample_q  <= sample_d;
      dv_q      <= dv_d;
      last_q    <= last_d;
      err_len_q <= err_len_d;
      overrun_q <= overrun_d;
`ifdef FRAME_CHECKSUM_EN
      sum_q     <= sum_d;
      err_chk_q <= err_chk_d;
`endif
    end
  end

  frame_sample_ram #(
    .DEPTH  (MAX_SAMPLES),
    .ADDR_W (ADDR_W),
    .DATA_W (SAMPLE_W)
  ) u_ram (
    .clk_i     (i_Clock),
    .wr_en_i   (wr_en),
    .wr_addr_i (idx_q[ADDR_W-1:0]),
    .wr_data_i ({i_Rx_Byte, low_q}),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_idx_q[ADDR_W-1:0]),
    .rd_data_o (ram_rd_data)
  );

  assign o_Sample_DV   = dv_q;
  assign o_Sample      = sample_q;
  assign o_Sample_Last = last_q;
  assign o_Err_Len     = err_len_q;
  assign o_Overrun     = overrun_q;
  assign o_Busy        = (state_q != s_IDLE);
`ifdef FRAME_CHECKSUM_EN
  assign o_Err_Chk     = err_chk_q;
`else
  assign o_Err_Chk     = 1'b0;
`endif

endmodule
